// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the wait-stated memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    localparam int          MAX_WAIT = 15;

endpackage

// File: rtl/mem_responder_spram.sv
// Single-port word RAM with byte-lane write enables and a registered read port.
module spram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [31:0] r_rdata;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'd0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Request/ready memory responder: latches a held request, waits WAIT_CYCLES+1
// cycles, then performs or rejects the access and pulses ready for one cycle.
//
// state | meaning
// IDLE  | waiting for req; latches request qualifiers when it is seen
// WAIT  | counting down wait states; access happens on the edge leaving cnt=0
// RESP  | ready high for this single cycle, then back to IDLE
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        MemWrite,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic [3:0]  be,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        err
);

    localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES);

    resp_state_t r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_adr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic        r_ready;
    logic        r_err;
    logic        r_bad_rd;

    logic        w_go;
    logic        w_valid;
    logic [31:0] w_rdata;

    assign w_go    = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_valid = (r_adr[1:0] == 2'b00) && ((r_adr >> (ADDR_WIDTH + 2)) == 32'd0);

    spram #(.ADDR_WIDTH(ADDR_WIDTH)) u_spram (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_go && w_valid),
        .i_we    (r_we),
        .i_be    (r_be),
        .i_addr  (r_adr[ADDR_WIDTH+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_adr    <= 32'd0;
            r_wdata  <= 32'd0;
            r_be     <= 4'd0;
            r_we     <= 1'b0;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_bad_rd <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_adr   <= adr;
                        r_wdata <= writedata;
                        r_be    <= be;
                        r_we    <= MemWrite;
                        r_cnt   <= CNT_LOAD;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        if (!w_valid) r_err <= 1'b1;
                        // Writes leave the read-data source untouched
                        if (!r_we) r_bad_rd <= !w_valid;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign readdata = r_bad_rd ? ERR_DATA : w_rdata;
    assign ready    = r_ready;
    assign err      = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, hand-written corner sequences and
// random accesses checked against an array-based model of the memory.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, MemWrite = 1'b0;
    logic [31:0] adr = '0, writedata = '0;
    logic [3:0]  be = '0;
    logic [31:0] readdata;
    logic        ready, err;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] adr0 = '0, wd0 = '0;
    logic [3:0]  be0 = '0;
    logic [31:0] rd0;
    logic        ready0, err0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .MemWrite(MemWrite), .adr(adr),
        .writedata(writedata), .be(be), .readdata(readdata), .ready(ready), .err(err)
    );

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .MemWrite(we0), .adr(adr0),
        .writedata(wd0), .be(be0), .readdata(rd0), .ready(ready0), .err(err0)
    );

    // Reference model: word array plus per-byte "has been written" flags.
    logic [31:0] m_mem   [0:1023];
    logic [3:0]  m_known [0:1023];
    logic [31:0] m_rd, m_mask;
    logic        m_err;

    function automatic logic [31:0] lane_mask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    function automatic void model_access(input logic w, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] b);
        int idx;
        idx = int'(a[11:2]);
        if (a % 4 != 0 || a >= 32'd4096) begin
            m_err = 1'b1;
            if (!w) begin
                m_rd   = 32'hDEAD_BEEF;
                m_mask = 32'hFFFF_FFFF;
            end
        end else if (w) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) begin
                    m_mem[idx][8*i +: 8] = d[8*i +: 8];
                    m_known[idx][i]      = 1'b1;
                end
            end
        end else begin
            m_rd   = m_mem[idx];
            m_mask = lane_mask(m_known[idx]);
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] mask);
        total++;
        if ((act & mask) !== (exp & mask)) begin
            bad++;
            $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act, exp, mask, $time);
        end
    endtask

    // Request is presented just after an edge ("edge k"); lat counts edges to ready.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd, output logic e);
        int lat;
        @(posedge clk); #1;
        req = 1'b1; MemWrite = w; adr = a; writedata = d; be = b;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready && lat < 40);
        rd = readdata;
        e  = err;
        req = 1'b0; MemWrite = 1'b0;
        model_access(w, a, d, b);
        chk("latency", 32'(lat), 32'd4, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("ready_single", {31'd0, ready}, 32'd0, 32'hFFFF_FFFF);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  b;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, pulses, last_edge, edge_n, sel;
        logic [31:0] ra;

        for (int i = 0; i < 1024; i++) begin
            m_mem[i] = '0; m_known[i] = '0;
        end
        m_rd = '0; m_mask = '1; m_err = 1'b0;

        tbl[0]  = '{1'b1, 32'h10,   32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 32'h10,   32'h0,         4'h0, 32'h1234_5678, 1'b0};
        tbl[2]  = '{1'b1, 32'h20,   32'hAABB_CCDD, 4'hF, 32'h1234_5678, 1'b0};
        tbl[3]  = '{1'b1, 32'h20,   32'h0000_0011, 4'h1, 32'h1234_5678, 1'b0};
        tbl[4]  = '{1'b0, 32'h20,   32'h0,         4'h0, 32'hAABB_CC11, 1'b0};
        tbl[5]  = '{1'b1, 32'h0,    32'hCAFE_F00D, 4'hF, 32'hAABB_CC11, 1'b0};
        tbl[6]  = '{1'b1, 32'h30,   32'h0,         4'hF, 32'hAABB_CC11, 1'b0};
        tbl[7]  = '{1'b0, 32'h22,   32'h0,         4'h0, 32'hDEAD_BEEF, 1'b1};
        tbl[8]  = '{1'b0, 32'h10,   32'h0,         4'h0, 32'h1234_5678, 1'b1};
        tbl[9]  = '{1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h1234_5678, 1'b1};
        tbl[10] = '{1'b0, 32'h0,    32'h0,         4'h0, 32'hCAFE_F00D, 1'b1};

        #12; rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_readdata", readdata, 32'd0, '1);
        chk("reset_ready", {31'd0, ready}, 32'd0, '1);
        chk("reset_err", {31'd0, err}, 32'd0, '1);

        for (int i = 0; i < 11; i++) begin
            access(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].b, rd, e);
            chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd, '1);
            chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err}, '1);
        end

        // Reset during the wait states of a write to 0x30 must abort it.
        @(posedge clk); #1;
        req = 1'b1; MemWrite = 1'b1; adr = 32'h30; writedata = 32'h5555_5555; be = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_readdata", readdata, 32'd0, '1);
        chk("abort_ready", {31'd0, ready}, 32'd0, '1);
        chk("abort_err", {31'd0, err}, 32'd0, '1);
        req = 1'b0; MemWrite = 1'b0;
        #3; rst = 1'b1;
        m_err = 1'b0; m_rd = '0; m_mask = '1;
        access(1'b0, 32'h30, 32'h0, 4'h0, rd, e);
        chk("abort_no_write", rd, 32'h0, '1);
        chk("abort_err_clear", {31'd0, e}, 32'd0, '1);

        // req held high across three reads: three pulses, 5 edges apart.
        @(posedge clk); #1;
        req = 1'b1; MemWrite = 1'b0; adr = 32'h10;
        pulses = 0; last_edge = 0;
        for (edge_n = 1; edge_n <= 24; edge_n++) begin
            @(posedge clk); #1;
            if (ready) begin
                pulses++;
                chk("held_rd", readdata, 32'h1234_5678, '1);
                chk("held_edge", 32'(edge_n), 32'(pulses * 5 - 1), '1);
                if (pulses == 3) req = 1'b0;
            end
        end
        chk("held_pulses", 32'(pulses), 32'd3, '1);

        // WAIT_CYCLES=0 instance: ready two edges after the request appears.
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            req0 = 1'b1; we0 = (j == 0); adr0 = 32'h40; wd0 = 32'h0BAD_CAFE; be0 = 4'hF;
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!ready0 && lat < 40);
            chk("w0_latency", 32'(lat), 32'd2, '1);
            if (j == 1) chk("w0_rd", rd0, 32'h0BAD_CAFE, '1);
            req0 = 1'b0;
        end
        chk("w0_err", {31'd0, err0}, 32'd0, '1);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      ra = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
            else if (sel == 1) ra = 32'h1000 << $urandom_range(0, 19);
            else               ra = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            access(1'($urandom), ra, $urandom, 4'($urandom), rd, e);
            chk("rand_rd", rd, m_rd, m_mask);
            chk("rand_err", {31'd0, e}, {31'd0, m_err}, '1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
